// File: rtl/calendar_pkg.sv
// calendar_pkg: BCD month constants, month lengths, the leap-year test
// evaluated on BCD digits, and BCD increment helpers for the calendar.
package calendar_pkg;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] LEN_28 = 8'h28;
  localparam logic [7:0] LEN_29 = 8'h29;
  localparam logic [7:0] LEN_30 = 8'h30;
  localparam logic [7:0] LEN_31 = 8'h31;

  localparam logic [7:0] DAY_FIRST = 8'h01;

  // A BCD pair TU is a multiple of 4 when T is even and U is 0/4/8,
  // or T is odd and U is 2/6.
  function automatic logic bcd_pair_div4(input logic [7:0] p);
    logic [3:0] u;
    u = p[3:0];
    if (p[4] == 1'b0)
      bcd_pair_div4 = (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
    else
      bcd_pair_div4 = (u == 4'd2) || (u == 4'd6);
  endfunction

  // Century years (low pair 00) are leap only when the high pair is a
  // multiple of 4, which covers the /100 and /400 exceptions.
  function automatic logic is_leap_bcd(input logic [15:0] year_bcd);
    if (year_bcd[7:0] == 8'h00)
      is_leap_bcd = bcd_pair_div4(year_bcd[15:8]);
    else
      is_leap_bcd = bcd_pair_div4(year_bcd[7:0]);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                               input logic leap);
    case (month_bcd)
      MON_FEB:                             days_in_month = leap ? LEN_29 : LEN_28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV:  days_in_month = LEN_30;
      default:                             days_in_month = LEN_31;
    endcase
  endfunction

  // 2-digit BCD +1, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    bcd_inc2 = r;
  endfunction

  // 4-digit BCD +1, 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [7:0] hi;
    hi = (v[7:0] == 8'h99) ? bcd_inc2(v[15:8]) : v[15:8];
    bcd_inc4 = {hi, bcd_inc2(v[7:0])};
  endfunction

endpackage

// File: rtl/calendar_counter_bcd_year_counter.sv
// bcd_year_counter: 4-digit BCD year register with enable, wraps 9999->0000.
// Ports: clk, rst (sync, active-high), en (count by one), year (BCD),
//        leap (combinational leap flag for the current year).
module bcd_year_counter
  import calendar_pkg::*;
#(
  parameter logic [15:0] YEAR_INIT = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] year,
  output logic        leap
);

  always_ff @(posedge clk) begin
    if (rst)
      year <= YEAR_INIT;
    else if (en)
      year <= bcd_inc4(year);
  end

  assign leap = is_leap_bcd(year);

endmodule

// File: rtl/calendar_counter.sv
// calendar_counter: BCD day/month/year calendar advanced by pulse_day from
// the time-of-day clock, with hold-to-advance adjust keys (Year > Month > Day).
// Ports: _1Hz clock, CR sync active-high reset, pulse_day strobe,
//        AdjDayKey/AdjMonKey/AdjYearKey, Year/Month/Day BCD outputs,
//        pulse_month/pulse_year combinational carry strobes.
module calendar_counter
  import calendar_pkg::*;
#(
  parameter logic [15:0] YEAR_INIT  = 16'h2000,
  parameter logic [7:0]  MONTH_INIT = 8'h01,
  parameter logic [7:0]  DAY_INIT   = 8'h01
) (
  input  logic        _1Hz,
  input  logic        CR,
  input  logic        pulse_day,
  input  logic        AdjDayKey,
  input  logic        AdjMonKey,
  input  logic        AdjYearKey,
  output logic [15:0] Year,
  output logic [7:0]  Month,
  output logic [7:0]  Day,
  output logic        pulse_month,
  output logic        pulse_year
);

  logic       leap;
  logic       year_en;
  logic       next_year_leap;
  logic [7:0] month_len;
  logic [7:0] month_next;
  logic [7:0] month_next_len;

  assign month_len      = days_in_month(Month, leap);
  assign month_next     = (Month == MON_DEC) ? MON_JAN : bcd_inc2(Month);
  assign month_next_len = days_in_month(month_next, leap);
  assign next_year_leap = is_leap_bcd(bcd_inc4(Year));

  assign pulse_month = pulse_day && (Day == month_len);
  assign pulse_year  = pulse_day && (Month == MON_DEC) && (Day == LEN_31);

  // Any key drops the natural advance, so only an unobstructed
  // pulse_year may carry into the year.
  assign year_en = AdjYearKey ||
                   (!AdjMonKey && !AdjDayKey && pulse_year);

  bcd_year_counter #(.YEAR_INIT(YEAR_INIT)) u_year (
    .clk  (_1Hz),
    .rst  (CR),
    .en   (year_en),
    .year (Year),
    .leap (leap)
  );

  always_ff @(posedge _1Hz) begin
    if (CR) begin
      Month <= MONTH_INIT;
      Day   <= DAY_INIT;
    end else if (AdjYearKey) begin
      if ((Month == MON_FEB) && (Day == LEN_29) && !next_year_leap)
        Day <= LEN_28;
    end else if (AdjMonKey) begin
      Month <= month_next;
      // BCD bytes of valid dates compare like their decimal values.
      if (Day > month_next_len)
        Day <= month_next_len;
    end else if (AdjDayKey) begin
      Day <= (Day == month_len) ? DAY_FIRST : bcd_inc2(Day);
    end else if (pulse_day) begin
      if (Day == month_len) begin
        Day   <= DAY_FIRST;
        Month <= month_next;
      end else begin
        Day <= bcd_inc2(Day);
      end
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        cr = 1'b0;
  logic        pulse_day = 1'b0;
  logic        kd = 1'b0, km = 1'b0, ky = 1'b0;
  logic [15:0] year;
  logic [7:0]  month, day;
  logic        pm, py;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calendar_counter dut (
    ._1Hz       (clk),
    .CR         (cr),
    .pulse_day  (pulse_day),
    .AdjDayKey  (kd),
    .AdjMonKey  (km),
    .AdjYearKey (ky),
    .Year       (year),
    .Month      (month),
    .Day        (day),
    .pulse_month(pm),
    .pulse_year (py)
  );

  typedef struct {
    logic [15:0] y;  logic [7:0] m;  logic [7:0] d;
    logic pd; logic kd; logic km; logic ky;
    logic [15:0] ey; logic [7:0] em; logic [7:0] ed;
    logic epm; logic epy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return b[15:12]*1000 + b[11:8]*100 + b[7:4]*10 + b[3:0];
  endfunction

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cr = 1'b1; pulse_day = 1'b0; kd = 1'b0; km = 1'b0; ky = 1'b0;
    tick();
    cr = 1'b0;
  endtask

  // from the 2000/01/01 reset state, reach a target date with the keys
  task automatic set_date(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
    int ys, ms, ds;
    ys = (bcd2int(y) - 2000 + 10000) % 10000;
    ms = bcd2int({8'h00, m}) - 1;
    ds = bcd2int({8'h00, d}) - 1;
    do_reset();
    ky = 1'b1; repeat (ys) tick(); ky = 1'b0;
    km = 1'b1; repeat (ms) tick(); km = 1'b0;
    kd = 1'b1; repeat (ds) tick(); kd = 1'b0;
  endtask

  task automatic add(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                     input logic p, input logic a_d, input logic a_m, input logic a_y,
                     input logic [15:0] ey, input logic [7:0] em, input logic [7:0] ed,
                     input logic epm, input logic epy);
    vec_t v;
    v.y = y; v.m = m; v.d = d; v.pd = p; v.kd = a_d; v.km = a_m; v.ky = a_y;
    v.ey = ey; v.em = em; v.ed = ed; v.epm = epm; v.epy = epy;
    vecs.push_back(v);
  endtask

  initial begin
    //   start date               pd kd km ky  expected date            pm py
    add(16'h2000, 8'h02, 8'h28, 1, 0, 0, 0, 16'h2000, 8'h02, 8'h29, 0, 0);
    add(16'h2000, 8'h02, 8'h29, 1, 0, 0, 0, 16'h2000, 8'h03, 8'h01, 1, 0);
    add(16'h1900, 8'h02, 8'h28, 1, 0, 0, 0, 16'h1900, 8'h03, 8'h01, 1, 0);
    add(16'h2100, 8'h02, 8'h28, 1, 0, 0, 0, 16'h2100, 8'h03, 8'h01, 1, 0);
    add(16'h2400, 8'h02, 8'h28, 1, 0, 0, 0, 16'h2400, 8'h02, 8'h29, 0, 0);
    add(16'h2023, 8'h02, 8'h28, 1, 0, 0, 0, 16'h2023, 8'h03, 8'h01, 1, 0);
    add(16'h2024, 8'h02, 8'h28, 1, 0, 0, 0, 16'h2024, 8'h02, 8'h29, 0, 0);
    add(16'h2023, 8'h12, 8'h31, 1, 0, 0, 0, 16'h2024, 8'h01, 8'h01, 1, 1);
    add(16'h9999, 8'h12, 8'h31, 1, 0, 0, 0, 16'h0000, 8'h01, 8'h01, 1, 1);
    add(16'h2023, 8'h04, 8'h15, 1, 0, 0, 0, 16'h2023, 8'h04, 8'h16, 0, 0);
    add(16'h2099, 8'h05, 8'h31, 1, 0, 0, 0, 16'h2099, 8'h06, 8'h01, 1, 0);
    add(16'h2023, 8'h01, 8'h31, 0, 0, 1, 0, 16'h2023, 8'h02, 8'h28, 0, 0);
    add(16'h2023, 8'h06, 8'h30, 0, 0, 1, 0, 16'h2023, 8'h07, 8'h30, 0, 0);
    add(16'h2023, 8'h12, 8'h05, 0, 0, 1, 0, 16'h2023, 8'h01, 8'h05, 0, 0);
    add(16'h2024, 8'h02, 8'h29, 0, 0, 0, 1, 16'h2025, 8'h02, 8'h28, 0, 0);
    add(16'h2023, 8'h01, 8'h31, 0, 1, 0, 0, 16'h2023, 8'h01, 8'h01, 0, 0);
    add(16'h2023, 8'h04, 8'h30, 1, 1, 0, 0, 16'h2023, 8'h04, 8'h01, 1, 0);
    add(16'h2024, 8'h12, 8'h31, 1, 0, 0, 1, 16'h2025, 8'h12, 8'h31, 1, 1);
    add(16'h2000, 8'h03, 8'h31, 1, 0, 1, 1, 16'h2001, 8'h03, 8'h31, 1, 0);

    // reset state
    do_reset();
    check("reset_year", year, 16'h2000);
    check("reset_month", month, 8'h01);
    check("reset_day", day, 8'h01);
    check("reset_no_x", {31'd0, $isunknown({year, month, day, pm, py})}, 32'd0);

    // 31 strobes through January
    for (int i = 1; i <= 31; i++) begin
      pulse_day = 1'b1;
      #1;
      check($sformatf("jan_pm_%0d", i), pm, (i == 31) ? 1 : 0);
      tick();
    end
    pulse_day = 1'b0;
    check("jan_end_date", {year, month, day}, {16'h2000, 8'h02, 8'h01});

    // vector table
    foreach (vecs[i]) begin
      set_date(vecs[i].y, vecs[i].m, vecs[i].d);
      check($sformatf("v%0d_start", i), {year, month, day}, {vecs[i].y, vecs[i].m, vecs[i].d});
      pulse_day = vecs[i].pd; kd = vecs[i].kd; km = vecs[i].km; ky = vecs[i].ky;
      #1;
      check($sformatf("v%0d_pm", i), pm, vecs[i].epm);
      check($sformatf("v%0d_py", i), py, vecs[i].epy);
      tick();
      pulse_day = 1'b0; kd = 1'b0; km = 1'b0; ky = 1'b0;
      check($sformatf("v%0d_date", i), {year, month, day}, {vecs[i].ey, vecs[i].em, vecs[i].ed});
    end

    // day key held 35 cycles in January: 01 -> 31 -> 01 -> 05
    do_reset();
    kd = 1'b1; repeat (35) tick(); kd = 1'b0;
    check("hold_day_35", {year, month, day}, {16'h2000, 8'h01, 8'h05});

    // month key held 14 cycles: 01 -> 03, year untouched
    km = 1'b1; repeat (14) tick(); km = 1'b0;
    check("hold_mon_14", {year, month, day}, {16'h2000, 8'h03, 8'h05});

    // reset coincident with pulse_day and a key
    cr = 1'b1; pulse_day = 1'b1; kd = 1'b1;
    tick();
    cr = 1'b0; pulse_day = 1'b0; kd = 1'b0;
    check("reset_wins", {year, month, day}, {16'h2000, 8'h01, 8'h01});

    // reset in the middle of a year-key hold
    ky = 1'b1; repeat (3) tick();
    cr = 1'b1; tick(); cr = 1'b0;
    check("reset_mid_adjust", {year, month, day}, {16'h2000, 8'h01, 8'h01});
    tick(); ky = 1'b0;
    check("adjust_after_reset", year, 16'h2001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, checks %0d", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
